// File: rtl/serial_frame_rx.sv
// Serial frame deserializer: hunts for the SFD nibble, assembles 16-bit frames and queues them in a show-ahead FIFO.
// Optional DST filtering is compiled in with `define SERIAL_FRAME_RX_ADDR_FILTER_EN.
module serial_frame_rx #(
  parameter logic [3:0] MAC_ADDRESS = 4'hA,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_bit,
  output logic [15:0]                   frame_out,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              frame_cnt,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic                          dbg_state
);

  localparam int             PW       = $clog2(FIFO_DEPTH);
  localparam logic [3:0]     SFD      = 4'b0101;
  localparam logic           HUNT     = 1'b0;
  localparam logic           CAPTURE  = 1'b1;
  localparam logic [PW:0]    FULL_CNT = (PW+1)'(FIFO_DEPTH);

  logic             state;
  logic [3:0]       win;
  logic [15:0]      shreg;
  logic [3:0]       bit_cnt;
  logic [15:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  logic [3:0]       win_next;
  logic             frame_done;
  logic [15:0]      frame_new;
  logic             addr_ok;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             push_drop;
  logic             unused_stale_bit;

  assign win_next   = {win[2:0], rx_bit};
  assign frame_done = (state == CAPTURE) && (bit_cnt == 4'd11);
  // shreg[11] still holds a pre-frame bit on the last capture cycle; the live bit comes from rx_bit.
  assign frame_new  = {shreg[15:12], shreg[10:0], rx_bit};
  assign unused_stale_bit = shreg[11];

`ifdef SERIAL_FRAME_RX_ADDR_FILTER_EN
  assign addr_ok = (frame_new[11:8] == MAC_ADDRESS) || (frame_new[11:8] == 4'hF);
`else
  logic unused_mac;
  assign unused_mac = ^MAC_ADDRESS;
  assign addr_ok    = 1'b1;
`endif

  // Handshake: a frame transfers on each rising edge where frame_valid && frame_ready;
  // frame_valid depends only on stored occupancy, never on frame_ready.
  assign pop       = (count != '0) && frame_ready;
  assign full      = (count == FULL_CNT);
  assign push_ok   = frame_done && addr_ok && (!full || pop);
  assign push_drop = frame_done && addr_ok && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HUNT;
      win     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (state == HUNT) begin
      win <= win_next;
      if (win_next == SFD) begin
        state         <= CAPTURE;
        bit_cnt       <= '0;
        shreg[15:12]  <= SFD;
      end
    end else begin
      shreg[11:0] <= {shreg[10:0], rx_bit};
      bit_cnt     <= bit_cnt + 4'd1;
      if (frame_done) begin
        state <= HUNT;
        win   <= '0;
      end
    end
  end

  // Writing the slot being popped is safe when full: the old head leaves on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= frame_new;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push_ok && (frame_cnt != '1)) frame_cnt <= frame_cnt + CNT_W'(1);
      if (push_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign frame_out   = mem[rd_ptr];
  assign frame_valid = (count != '0);
  assign fifo_count  = count;
  assign dbg_state   = state;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: latency, back-to-back frames, overflow, full+pop, mid-frame reset, saturation.
module tb_serial_frame_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_bit = 1'b0;
  logic        frame_ready = 1'b0;
  logic [15:0] frame_out;
  logic        frame_valid;
  logic [2:0]  fifo_count;
  logic [7:0]  frame_cnt;
  logic [7:0]  drop_cnt;
  logic        dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  serial_frame_rx #(.MAC_ADDRESS(4'hA), .FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .rx_bit(rx_bit),
    .frame_out(frame_out), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .fifo_count(fifo_count), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_bit = 1'b0;
    frame_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drivers: inputs change on the falling edge, outputs are checked on the falling edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_bit = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] f, input logic ready_last);
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk);
      rx_bit = f[i];
      if (i == 0 && ready_last) frame_ready = 1'b1;
    end
  endtask

  task automatic drain();
    logic [15:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("drain_valid", 32'(frame_valid), 32'd1);
      check("drain_frame", 32'(frame_out), 32'(e));
      frame_ready = 1'b1;
      @(negedge clk);
      frame_ready = 1'b0;
    end
    check("drain_empty", 32'(frame_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] part;
    part = 16'h5D80;

    // Reset state
    @(negedge clk);
    check("rst_frame_out", 32'(frame_out), 32'h0);
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef SERIAL_FRAME_RX_ADDR_FILTER_EN
    idle(4);
    send_frame(16'h5BA1, 1'b0);
    send_frame(16'h5AB2, 1'b0);
    send_frame(16'h5FC3, 1'b0);
    idle(2);
    check("flt_frame_cnt", 32'(frame_cnt), 32'd2);
    check("flt_drop_cnt", 32'(drop_cnt), 32'd0);
    check("flt_count", 32'(fifo_count), 32'd2);
    exp_q.push_back(16'h5AB2);
    exp_q.push_back(16'h5FC3);
    drain();
`else
    // Single frame and latency: valid must appear exactly after the last payload bit's edge
    idle(8);
    send_frame(16'h5BA7, 1'b0);
    check("lat_early", 32'(frame_valid), 32'd0);
    idle(1);
    check("lat_valid", 32'(frame_valid), 32'd1);
    check("t1_frame", 32'(frame_out), 32'h5BA7);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t1_count", 32'(fifo_count), 32'd1);
    exp_q.push_back(16'h5BA7);
    drain();

    // Body containing 0101, then zero-gap back-to-back frame
    send_frame(16'h5C55, 1'b0);
    send_frame(16'h5AB3, 1'b0);
    idle(3);
    check("b2b_count", 32'(fifo_count), 32'd2);
    check("b2b_frame_cnt", 32'(frame_cnt), 32'd3);
    check("b2b_state", 32'(dbg_state), 32'd0);
    exp_q.push_back(16'h5C55);
    exp_q.push_back(16'h5AB3);
    drain();

    // Overflow: five frames into a depth-4 FIFO
    do_reset();
    idle(2);
    send_frame(16'h5111, 1'b0);
    send_frame(16'h5222, 1'b0);
    send_frame(16'h5333, 1'b0);
    send_frame(16'h5444, 1'b0);
    send_frame(16'h5555, 1'b0);
    idle(2);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_frame_cnt", 32'(frame_cnt), 32'd4);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
    exp_q.push_back(16'h5111);
    exp_q.push_back(16'h5222);
    exp_q.push_back(16'h5333);
    exp_q.push_back(16'h5444);
    drain();

    // Full FIFO with a pop on the frame-complete edge
    do_reset();
    send_frame(16'h5A01, 1'b0);
    send_frame(16'h5A02, 1'b0);
    send_frame(16'h5A03, 1'b0);
    send_frame(16'h5A04, 1'b0);
    idle(1);
    check("fp_full", 32'(fifo_count), 32'd4);
    send_frame(16'h5F0F, 1'b1);
    idle(1);
    frame_ready = 1'b0;
    check("fp_count", 32'(fifo_count), 32'd4);
    check("fp_drop_cnt", 32'(drop_cnt), 32'd0);
    check("fp_frame_cnt", 32'(frame_cnt), 32'd5);
    exp_q.push_back(16'h5A02);
    exp_q.push_back(16'h5A03);
    exp_q.push_back(16'h5A04);
    exp_q.push_back(16'h5F0F);
    drain();

    // Reset after SFD plus 6 captured bits
    for (int i = 15; i >= 6; i--) begin
      @(negedge clk);
      rx_bit = part[i];
    end
    do_reset();
    check("mid_state", 32'(dbg_state), 32'd0);
    check("mid_count", 32'(fifo_count), 32'd0);
    check("mid_frame_cnt", 32'(frame_cnt), 32'd0);
    send_frame(16'h5DA1, 1'b0);
    idle(2);
    check("mid_after_cnt", 32'(frame_cnt), 32'd1);
    check("mid_after_count", 32'(fifo_count), 32'd1);
    exp_q.push_back(16'h5DA1);
    drain();

    // Counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) send_frame(16'h5123, 1'b0);
    idle(2);
    check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
    check("sat_frame_cnt4", 32'(frame_cnt), 32'd4);
    frame_ready = 1'b1;
    for (int i = 0; i < 260; i++) send_frame(16'h5321, 1'b0);
    idle(3);
    frame_ready = 1'b0;
    check("sat_frame_cnt", 32'(frame_cnt), 32'd255);
    check("sat_drop_hold", 32'(drop_cnt), 32'd255);
    check("sat_empty", 32'(fifo_count), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
